// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipelined_cla_adder: K-bit-per-stage pipelined CLA add/sub, stream |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipelined_cla_adder #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ovf
);

  localparam int STAGES = N / K;
  localparam int GROUPS = K / 4;
  localparam int LAST   = STAGES - 1;

  if (((N % K) != 0) || ((K % 4) != 0)) begin : g_param_check
    $error("pipelined_cla_adder: N=%0d must be a multiple of K=%0d and K a multiple of 4", N, K);
  end

  // One K-bit slice: 4-bit lookahead groups, group carry chained across the slice.
  function automatic logic [K:0] cla_slice(input logic [K-1:0] a,
                                           input logic [K-1:0] bx,
                                           input logic         ci);
    logic [K-1:0] g, p, s;
    logic [3:0]   gg, pp;
    logic [4:0]   cc;
    logic         c;
    g = a & bx;
    p = a ^ bx;
    s = '0;
    c = ci;
    for (int grp = 0; grp < GROUPS; grp++) begin
      gg    = g[grp*4 +: 4];
      pp    = p[grp*4 +: 4];
      cc[0] = c;
      cc[1] = gg[0] | (pp[0] & c);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c);
      cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
            | ((&pp) & c);
      s[grp*4 +: 4] = pp ^ cc[3:0];
      c = cc[4];
    end
    return {c, s};
  endfunction

  logic         w_en;
  logic [N-1:0] w_bx_in;
  logic         w_c0;

  logic [N-1:0] w_a_src    [STAGES];
  logic [N-1:0] w_bx_src   [STAGES];
  logic [N-1:0] w_sum_src  [STAGES];
  logic [N-1:0] w_sum_next [STAGES];
  logic         w_c_src    [STAGES];
  logic         w_v_src    [STAGES];
  logic         w_co       [STAGES];

  logic [N-1:0] r_a     [STAGES];
  logic [N-1:0] r_bx    [STAGES];
  logic [N-1:0] r_sum   [STAGES];
  logic         r_carry [STAGES];
  logic         r_valid [STAGES];

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_bx_in  = sub ? ~B : B;
  assign w_c0     = sub | Cin;

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam logic [N-1:0] SLICE_MASK = N'({K{1'b1}}) << (j*K);
    logic [K:0] w_slice;

    if (j == 0) begin : g_head
      assign w_a_src[j]   = A;
      assign w_bx_src[j]  = w_bx_in;
      assign w_c_src[j]   = w_c0;
      assign w_v_src[j]   = in_valid;
      assign w_sum_src[j] = '0;
    end else begin : g_tail
      assign w_a_src[j]   = r_a[j-1];
      assign w_bx_src[j]  = r_bx[j-1];
      assign w_c_src[j]   = r_carry[j-1];
      assign w_v_src[j]   = r_valid[j-1];
      assign w_sum_src[j] = r_sum[j-1];
    end

    assign w_slice       = cla_slice(w_a_src[j][j*K +: K], w_bx_src[j][j*K +: K], w_c_src[j]);
    assign w_co[j]       = w_slice[K];
    assign w_sum_next[j] = (w_sum_src[j] & ~SLICE_MASK) | (N'(w_slice[K-1:0]) << (j*K));
  end

  // Operands ride along with their partial sum so each stage sees its own slice in step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < STAGES; j++) begin
        r_valid[j] <= 1'b0;
        r_carry[j] <= 1'b0;
        r_a[j]     <= '0;
        r_bx[j]    <= '0;
        r_sum[j]   <= '0;
      end
    end else if (w_en) begin
      for (int j = 0; j < STAGES; j++) begin
        r_valid[j] <= w_v_src[j];
        r_carry[j] <= w_co[j];
        r_a[j]     <= w_a_src[j];
        r_bx[j]    <= w_bx_src[j];
        r_sum[j]   <= w_sum_next[j];
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign S         = r_sum[LAST];
  assign Cout      = r_carry[LAST];
  // Overflow is formed from registered MSBs only, so no input reaches an output combinationally.
  assign Ovf       = (r_a[LAST][N-1] == r_bx[LAST][N-1]) && (r_sum[LAST][N-1] != r_a[LAST][N-1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipelined_cla_adder: self-checking bench for pipelined_cla_adder|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pipelined_cla_adder;

  localparam int N   = 32;
  localparam int K   = 8;
  localparam int STG = N / K;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sb = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  s;
  logic          cout;
  logic          ovf;

  logic [63:0]   sw_a = '0;
  logic [63:0]   sw_b = '0;
  logic          sw_cin = 1'b0;
  logic          sw_sub = 1'b0;
  logic          sw_valid = 1'b0;
  logic          sw_ready = 1'b1;
  logic          v16, r16, c16, o16;
  logic [15:0]   s16;
  logic          v64, r64, c64, o64;
  logic [63:0]   s64;
  logic          v8, r8, c8, o8;
  logic [7:0]    s8;

  logic [63:0]   ha [400];
  logic [63:0]   hb [400];
  logic          hc [400];
  logic          hs [400];
  logic          hv [400];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .sub(sb),
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .Cout(cout), .Ovf(ovf)
  );

  pipelined_cla_adder #(.N(16), .K(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r16),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .Cin(sw_cin), .sub(sw_sub),
    .out_valid(v16), .out_ready(sw_ready), .S(s16), .Cout(c16), .Ovf(o16)
  );

  pipelined_cla_adder #(.N(64), .K(16)) u64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r64),
    .A(sw_a), .B(sw_b), .Cin(sw_cin), .sub(sw_sub),
    .out_valid(v64), .out_ready(sw_ready), .S(s64), .Cout(c64), .Ovf(o64)
  );

  pipelined_cla_adder #(.N(8), .K(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8),
    .A(sw_a[7:0]), .B(sw_b[7:0]), .Cin(sw_cin), .sub(sw_sub),
    .out_valid(v8), .out_ready(sw_ready), .S(s8), .Cout(c8), .Ovf(o8)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic on n-bit operands; returns {ovf, cout, sum}.
  function automatic logic [65:0] ref_model(input int n, input logic [63:0] a_i,
                                            input logic [63:0] b_i, input logic c_i,
                                            input logic s_i);
    logic [64:0] mask, full;
    logic [63:0] am, bx;
    logic        c0, ov;
    mask = (65'd1 << n) - 65'd1;
    am   = a_i & mask[63:0];
    bx   = (s_i ? ~b_i : b_i) & mask[63:0];
    c0   = s_i ? 1'b1 : c_i;
    full = {1'b0, am} + {1'b0, bx} + {64'd0, c0};
    ov   = (am[n-1] == bx[n-1]) && (full[n-1] != am[n-1]);
    return {ov, full[n], full[63:0] & mask[63:0]};
  endfunction

  task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                            input logic tc, input logic ts, input logic [31:0] es,
                            input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sb = ts; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, " latency"}, lat, STG);
    check({tag, " S"}, s, es);
    check({tag, " Cout"}, cout, ec);
    check({tag, " Ovf"}, ovf, eo);
    @(negedge clk);
    check({tag, " single valid"}, out_valid, 0);
  endtask

  task automatic check_sweep(input string tag, input int n, input int stg, input int t,
                             input logic ov, input logic ir, input logic [63:0] os,
                             input logic oc, input logic oo);
    logic        ev;
    logic [65:0] r;
    ev = (t >= stg) ? hv[t-stg] : 1'b0;
    check({tag, " in_ready"}, ir, 1);
    check({tag, " valid"}, ov, ev);
    if (ev) begin
      r = ref_model(n, ha[t-stg], hb[t-stg], hc[t-stg], hs[t-stg]);
      check({tag, " S"}, os, r[63:0]);
      check({tag, " Cout"}, oc, r[64]);
      check({tag, " Ovf"}, oo, r[65]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [65:0] q[$];
    logic [65:0] r;
    logic [31:0] ra, rb;
    logic        rc, rs, stall;
    int          sent, got, issued, idle_t;

    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset S", s, 0);
    check("reset Cout", cout, 0);
    check("reset Ovf", ovf, 0);
    check("reset in_ready", in_ready, 1);
    rst = 1'b0;

    run_single("add",      32'd1209,     32'd4565, 1'b0, 1'b0, 32'd5774,     1'b0, 1'b0);
    run_single("ripple",   32'hFFFFFFFF, 32'd0,    1'b1, 1'b0, 32'd0,        1'b1, 1'b0);
    run_single("add ovf",  32'h7FFFFFFF, 32'd1,    1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_single("sub",      32'd5,        32'd7,    1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_single("sub ovf",  32'h80000000, 32'd1,    1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Streaming with a three-cycle downstream stall.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      stall     = (cyc >= 6 && cyc < 9);
      out_ready = !stall;
      #1;
      check("stream in_ready", in_ready, !stall);
      if (stall) check("stream stall valid", out_valid, 1);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("stream extra output", out_valid, 0);
        end else begin
          r = q[0];
          check("stream S", s, r[31:0]);
          check("stream Cout", cout, r[64]);
          check("stream Ovf", ovf, r[65]);
          if (!stall) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (sent < 8) begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        a = ra; b = rb; cin = rc; sb = rs; in_valid = 1'b1;
        if (!stall) begin
          q.push_back(ref_model(32, {32'd0, ra}, {32'd0, rb}, rc, rs));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream count", got, 8);
    check("stream leftover", q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      check("stream drained", out_valid, 0);
    end

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; cin = 1'b0; sb = 1'b0; in_valid = 1'b1;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst S", s, 0);
    check("midrst Cout", cout, 0);
    check("midrst in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("midrst no stale", out_valid, 0);
    end
    run_single("post rst", 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0);

    // Parameter sweep: all three instances share stimulus, latency checked cycle-exactly.
    issued = 0;
    idle_t = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      check_sweep("n16", 16, 4, t, v16, r16, {48'd0, s16}, c16, o16);
      check_sweep("n64", 64, 4, t, v64, r64, s64, c64, o64);
      check_sweep("n8",  8,  1, t, v8,  r8,  {56'd0, s8},  c8,  o8);
      if (idle_t >= 0 && t >= idle_t + 5) break;
      hv[t] = (issued < 200) && ($urandom_range(0, 7) != 0);
      ha[t] = {$urandom, $urandom};
      hb[t] = {$urandom, $urandom};
      hc[t] = 1'($urandom_range(0, 1));
      hs[t] = 1'($urandom_range(0, 1));
      sw_a = ha[t]; sw_b = hb[t]; sw_cin = hc[t]; sw_sub = hs[t]; sw_valid = hv[t];
      if (hv[t]) issued++;
      if (issued == 200 && idle_t < 0) idle_t = t;
    end
    sw_valid = 1'b0;
    check("sweep issued", issued, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. The N-bit operation is split into N/K slices of K bits. Each pipeline stage resolves one slice with internal 4-bit lookahead groups and registers the inter-slice carry. It is the clocked, throughput-oriented successor to the team's combinational N-bit CLA, for datapaths where a full-width ripple of lookahead groups does not close timing.

## Interface
- N, 32, operand/result width; must be a multiple of K
- K, 8, bits resolved per pipeline stage; must be a multiple of 4
- STAGES, N/K (derived, not overridable), pipeline depth
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- A  input  N  operand A (two's complement or unsigned)
- B  input  N  operand B
- Cin  input  1  carry-in (add mode only)
- sub  input  1  0 = A+B+Cin, 1 = A−B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- S  output  N  sum/difference
- Cout  output  1  carry-out of MSB (sub: 1 = no borrow)
- Ovf  output  1  signed overflow

## Operation
- Operand preparation: Bx = sub ? ~B : B; c0 = sub ? 1 : Cin. Cin is ignored when sub=1.
- Slice j covers bits [jK+K−1 : jK]. Inside a slice, per bit: G = A&Bx, P = A^Bx. Carries use 4-bit lookahead groups, with group G/P chained across the slice. S = P ^ carry.
- Stage j computes slice j using carry-in from stage j−1's registered carry (stage 0 uses c0). It registers sum slice j and carry-out.
- Skew registers:
  - Upper slices of A/Bx/sub wait until their stage.
  - Completed lower sum slices are delayed so all N bits of one operation leave together.
- Results:
  - Cout = carry out of bit N−1.
  - Ovf = (A[N−1] == Bx[N−1]) && (S[N−1] != A[N−1]).
  - Arithmetic is modulo 2^N; no saturation.
- One valid bit per stage travels with the data. Bubbles are carried as invalid stages.
- Global enable: en = !out_valid || out_ready. All stage registers advance only when en=1. in_ready = en, combinationally.
- Accept: in_valid && in_ready at a rising edge. When in_valid=0 and en=1, an invalid bubble enters stage 0.
- Stall: while out_valid && !out_ready, S/Cout/Ovf/out_valid hold stable, every stage holds, and in_ready=0.

## Timing
- Reset (asynchronous assert, any time):
  - All stage valid bits clear; out_valid=0; S=0; Cout=0; Ovf=0.
  - All data and skew registers clear to 0.
  - in_ready=1 (follows en).
  - Operations in flight are discarded, never emitted.
- Reset release: the first accept is possible at the first rising edge with rst=0.
- Latency: operands accepted at the edge ending cycle c produce out_valid=1 in cycle c+STAGES, with no stalls. Each stall cycle adds one cycle.
- Throughput: one operation per cycle when out_ready is held high.
- Simultaneous output consume and input accept at the same edge is legal. The pipeline shifts by one with no bubble inserted.
- No combinational path from A/B/Cin/sub to any output. The only combinational path is out_ready→in_ready.
- STAGES=1 (K=N) is legal: a single registered stage with latency 1.
- Parameter check: a simulation-time error is raised if N%K≠0 or K%4≠0.

## Test plan
- Add, N=32, K=8: A=1209, B=4565, Cin=0, sub=0 → after 4 cycles S=5774, Cout=0, Ovf=0, out_valid=1 for exactly one cycle with out_ready=1.
- Full carry ripple across all slices: A=0xFFFFFFFF, B=0, Cin=1 → S=0, Cout=1, Ovf=0. Then A=0x7FFFFFFF, B=1, Cin=0 → S=0x80000000, Cout=0, Ovf=1.
- Subtract: A=5, B=7, sub=1, Cin=1 (ignored) → S=0xFFFFFFFE, Cout=0, Ovf=0. Then A=0x80000000, B=1, sub=1 → S=0x7FFFFFFF, Cout=1, Ovf=1.
- Back-to-back plus backpressure:
  - Stream 8 random operations with in_valid=1. Drop out_ready for 3 cycles mid-stream.
  - Required: in_ready=0 during the stall, and outputs held stable.
  - All 8 results in order, matching a reference model; no loss or duplication.
- Reset mid-flight: assert rst with 3 operations in flight → out_valid=0 and S=0 immediately. After release, no stale result appears. A new operation returns its correct result after 4 cycles.
- Parameter sweep: N=16/K=4, N=64/K=16, N=8/K=8 with 200 random add/sub vectors each → all results match the model; latency equals N/K.
